// File: rtl/aes_pkg.sv
// Shared AES definitions: default sizes, round-mode encoding and GF(2^8) arithmetic.
package aes_pkg;

  localparam int unsigned RND_SIZE = 128;
  localparam int unsigned WRD_SIZE = 32;
  localparam int unsigned CNT_SIZE = 4;
  localparam int unsigned NUM_BLK  = 4;
  localparam int unsigned NR       = 10;

  typedef enum logic [1:0] {
    ModeBypass,
    ModeFull,
    ModeFinal
  } rnd_mode_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine map followed by the GF(2^8) inverse.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] cipher_byte,
  output logic [7:0] plain_byte
);

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] pre;
    logic [7:0] sq;
    logic [7:0] inv;
    pre = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as AES requires
    sq  = pre;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv;
  endfunction

  assign plain_byte = inv_sbox(cipher_byte);

endmodule

// File: rtl/aes_inv_round.sv
// Two-stage AES inverse round: stage 1 InvShiftRows/InvSubBytes, stage 2 AddRoundKey and
// InvMixColumns, with round mode chosen from the inverse round index.
module aes_inv_round
  import aes_pkg::*;
#(
  parameter int unsigned RND_SIZE = aes_pkg::RND_SIZE,
  parameter int unsigned WRD_SIZE = aes_pkg::WRD_SIZE,
  parameter int unsigned CNT_SIZE = aes_pkg::CNT_SIZE,
  parameter int unsigned NUM_BLK  = aes_pkg::NUM_BLK,
  parameter int unsigned NR       = aes_pkg::NR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_rnd_en,
  input  logic [RND_SIZE-1:0] i_rnd_text,
  input  logic [RND_SIZE-1:0] i_rnd_key,
  input  logic [CNT_SIZE-1:0] i_rnd_cnt,
  output logic [RND_SIZE-1:0] o_rnd_plain,
  output logic                o_rnd_valid,
  output logic                o_rnd_last
);

  localparam int unsigned ROWS   = WRD_SIZE / 8;
  localparam int unsigned NBYTES = RND_SIZE / 8;

  typedef logic [RND_SIZE-1:0] state_t;

  // Byte (r, c) sits at column-major index ROWS*c + r, byte 0 in the MSBs.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < NUM_BLK; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        o[RND_SIZE-1-8*(ROWS*c+r) -: 8] =
          s[RND_SIZE-1-8*(ROWS*((c-r+NUM_BLK)%NUM_BLK)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t     o;
    logic [7:0] a [ROWS];
    logic [7:0] m [ROWS];
    logic [7:0] acc;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o = '0;
    for (int c = 0; c < NUM_BLK; c++) begin
      for (int r = 0; r < ROWS; r++) a[r] = s[RND_SIZE-1-8*(ROWS*c+r) -: 8];
      for (int r = 0; r < ROWS; r++) begin
        acc = '0;
        for (int j = 0; j < ROWS; j++) acc ^= gf_mul(m[(j-r+ROWS)%ROWS], a[j]);
        o[RND_SIZE-1-8*(ROWS*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  // Stage 1 datapath
  state_t    shifted;
  state_t    subbed;
  rnd_mode_e mode_d;

  assign shifted = inv_shift_rows(i_rnd_text);

  for (genvar k = 0; k < NBYTES; k++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .cipher_byte(shifted[8*k +: 8]),
      .plain_byte (subbed[8*k +: 8])
    );
  end

  // Indices beyond NR are a sequencer error; they behave as the final round.
  always_comb begin
    mode_d = ModeFull;
    if (i_rnd_cnt == '0) begin
      mode_d = ModeBypass;
    end else if (i_rnd_cnt >= CNT_SIZE'(NR)) begin
      mode_d = ModeFinal;
    end
  end

  logic      s1_valid_q;
  rnd_mode_e s1_mode_q;
  state_t    s1_key_q;
  state_t    s1_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= ModeBypass;
      s1_key_q   <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= i_rnd_en;
      if (i_rnd_en) begin
        s1_mode_q <= mode_d;
        s1_key_q  <= i_rnd_key;
        s1_data_q <= (mode_d == ModeBypass) ? i_rnd_text : subbed;
      end
    end
  end

  // Stage 2 datapath
  state_t added;
  state_t mixed;

  assign added = s1_data_q ^ s1_key_q;
  assign mixed = inv_mix_columns(added);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rnd_valid <= 1'b0;
      o_rnd_last  <= 1'b0;
      o_rnd_plain <= '0;
    end else begin
      o_rnd_valid <= s1_valid_q;
      o_rnd_last  <= s1_valid_q && (s1_mode_q == ModeFinal);
      if (s1_valid_q) begin
        o_rnd_plain <= (s1_mode_q == ModeFull) ? mixed : added;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_round.sv
// Scoreboard bench for aes_inv_round: directed FIPS-197 vectors, reset, round trip and random.
module tb_aes_inv_round;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [127:0] text = '0;
  logic [127:0] key = '0;
  logic [3:0]   cnt = '0;
  logic [127:0] plain;
  logic         valid;
  logic         last;

  always #5 clk = ~clk;

  aes_inv_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rnd_en   (en),
    .i_rnd_text (text),
    .i_rnd_key  (key),
    .i_rnd_cnt  (cnt),
    .o_rnd_plain(plain),
    .o_rnd_valid(valid),
    .o_rnd_last (last)
  );

  typedef struct {
    logic [127:0] data;
    logic         last;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  logic [7:0]   sbox[256];
  logic [7:0]   isbox[256];
  logic [127:0] rk[11];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Carry-less product, then reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= ({8'h00, a} << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox[x]  = s;
      isbox[s] = x[7:0];
    end
  endtask

  task automatic expand_key(input logic [127:0] k0);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
        rcon = m_mul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] st(input logic [127:0] v, input int r, input int c);
    return v[127-8*(4*c+r) -: 8];
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] t, input logic [127:0] k,
                                             input int n);
    logic [127:0] w;
    logic [127:0] o;
    if (n == 0) return t ^ k;
    w = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) w[127-8*(4*c+r) -: 8] = isbox[st(t, r, (c - r + 4) % 4)];
    w ^= k;
    if (n >= NR) return w;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = m_mul(8'h0e, st(w, r, c)) ^ m_mul(8'h0b, st(w, (r+1)%4, c)) ^
                                m_mul(8'h0d, st(w, (r+2)%4, c)) ^ m_mul(8'h09, st(w, (r+3)%4, c));
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [127:0] t, input logic [127:0] k, input int n,
                       input logic [127:0] exp_data);
    exp_t e;
    en   = 1'b1;
    text = t;
    key  = k;
    cnt  = n[3:0];
    e.data = exp_data;
    e.last = (n >= NR);
    e.due  = cyc + 2;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checks++;
        if (valid !== 1'b0 || last !== 1'b0 || plain !== '0) begin
          errors++;
          $display("FAIL reset_state: got valid=%b last=%b out=%h, required 0/0/0",
                   valid, last, plain);
        end
      end else if (valid === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got valid=1 out=%h at cyc=%0d, required no output",
                   plain, cyc);
        end else begin
          e = sbq.pop_front();
          if (plain !== e.data || last !== e.last || cyc != e.due) begin
            errors++;
            $display("FAIL result: got out=%h last=%b cyc=%0d, required out=%h last=%b cyc=%0d",
                     plain, last, cyc, e.data, e.last, e.due);
          end
        end
      end else begin
        checks++;
        if (valid !== 1'b0 || last !== 1'b0) begin
          errors++;
          $display("FAIL idle_flags: got valid=%b last=%b, required 0/0", valid, last);
        end
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          e = sbq.pop_front();
          errors++;
          $display("FAIL missing_valid: got valid=0 at cyc=%0d, required out=%h at cyc=%0d",
                   cyc, e.data, e.due);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] R1   = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] K9   = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] R2   = 128'h54d990a16ba09ab596bbf40ea111702f;
  localparam logic [127:0] R10  = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] t;
    logic [127:0] k;
    logic [127:0] nx;
    int           n;

    build_tables();
    expand_key(K0);

    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Directed FIPS-197 C.1 steps, isolated
    issue(CT, K10, 0, R1);
    idle(3);
    issue(R1, K9, 1, R2);
    idle(3);
    issue(R10, K0, NR, PT);
    idle(3);

    // Back-to-back with a bubble: requests on cycles 0, 1, 3
    issue(CT, K10, 0, R1);
    issue(R1, K9, 1, R2);
    idle(1);
    issue(R10, K0, NR, PT);
    idle(4);

    // Reset with a request in flight: that request must never appear
    en   = 1'b1;
    text = R1;
    key  = K9;
    cnt  = 4'd1;
    @(posedge clk);
    #1;
    en    = 1'b0;
    rst_n = 1'b0;
    sbq.delete();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    issue('0, '0, 0, '0);
    idle(3);

    // Round trip through all 11 steps, back-to-back
    t = CT;
    for (int i = 0; i <= NR; i++) begin
      nx = (i == NR) ? PT : ref_round(t, rk[NR-i], i);
      issue(t, rk[NR-i], i, nx);
      t = nx;
    end
    idle(3);

    // Random traffic, including out-of-range indices
    for (int i = 0; i < 200; i++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      n = $urandom_range(0, 15);
      issue(t, k, n, ref_round(t, k, n));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(5);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding results, required 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
